// File: rtl/data_cache_ram_if.sv
// Port bundle between the L1 data-cache controller and its data array.
// Port A carries CPU hits; port B carries refill/writeback traffic.
interface data_cache_ram_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              enb;
    logic [NB-1:0]     wea;
    logic [NB-1:0]     web;
    logic [ADDR_W-1:0] ada;
    logic [ADDR_W-1:0] adb;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] dout;

    modport master (
        output enb, wea, web, ada, adb, dina, dinb,
        input  dout
    );

    modport slave (
        input  enb, wea, web, ada, adb, dina, dinb,
        output dout
    );
endinterface

// File: rtl/data_cache_ram.sv
// L1 data-cache data array: two byte-maskable write ports, one combinational read
// output steered by enb. Port B wins same-lane collisions so refill data sticks.
module data_cache_ram #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 4,
    parameter int DATA_W = 32
) (
    input  logic            aclk,
    input  logic            aresetn,
    data_cache_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = ADDR_W - LINE_W;

    // Addresses are {line index, word-in-line}; split/join keeps that layout explicit.
    logic [IDX_W-1:0]  a_idx;
    logic [LINE_W-1:0] a_word;
    logic [IDX_W-1:0]  b_idx;
    logic [LINE_W-1:0] b_word;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] rd_word;

    assign a_idx  = bus.ada[ADDR_W-1:LINE_W];
    assign a_word = bus.ada[LINE_W-1:0];
    assign b_idx  = bus.adb[ADDR_W-1:LINE_W];
    assign b_word = bus.adb[LINE_W-1:0];
    assign a_addr = {a_idx, a_word};
    assign b_addr = {b_idx, b_word};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic       a_we;
            logic       b_we;

            // Writes are held off while reset is asserted; the array itself is never cleared.
            assign a_we = aresetn & bus.wea[gi];
            assign b_we = aresetn & bus.enb & bus.web[gi];

            // Port B is written last so it overrides port A on a same-word, same-lane hit.
            always_ff @(posedge aclk) begin
                if (a_we) begin
                    mem_lane[a_addr] <= bus.dina[8*gi +: 8];
                end
                if (b_we) begin
                    mem_lane[b_addr] <= bus.dinb[8*gi +: 8];
                end
            end

            // Zero-latency read: the writeback path uses dout as wdata on the same edge.
            assign rd_word[8*gi +: 8] = bus.enb ? mem_lane[b_addr] : mem_lane[a_addr];
        end
    endgenerate

    assign bus.dout = rd_word;
endmodule

// File: tb/tb_data_cache_ram.sv
// Randomised and directed check of data_cache_ram against a word-array reference model.
module tb_data_cache_ram;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic aclk;
    logic aresetn;

    data_cache_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    data_cache_ram #(.ADDR_W(ADDR_W), .LINE_W(4), .DATA_W(DATA_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [31:0] model [DEPTH];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // One clock of traffic: drive, optionally check the pre-edge read, then apply the edge to the model.
    task automatic step(input logic en, input logic [3:0] wa, input logic [3:0] wb,
                        input logic [9:0] aa, input logic [9:0] ab,
                        input logic [31:0] da, input logic [31:0] db,
                        input logic rn, input bit do_chk, input string tag);
        @(negedge aclk);
        aresetn     = rn;
        bus_if.enb  = en;
        bus_if.wea  = wa;
        bus_if.web  = wb;
        bus_if.ada  = aa;
        bus_if.adb  = ab;
        bus_if.dina = da;
        bus_if.dinb = db;
        #1;
        if (do_chk) chk(tag, bus_if.dout, en ? model[ab] : model[aa]);
        @(posedge aclk);
        if (rn) begin
            model[aa] = (model[aa] & ~bmask(wa)) | (da & bmask(wa));
            if (en) model[ab] = (model[ab] & ~bmask(wb)) | (db & bmask(wb));
        end
    endtask

    task automatic peek(input logic en, input logic [9:0] aa, input logic [9:0] ab,
                        input logic [31:0] exp, input string tag);
        @(negedge aclk);
        bus_if.enb = en;
        bus_if.wea = 4'h0;
        bus_if.web = 4'h0;
        bus_if.ada = aa;
        bus_if.adb = ab;
        #1;
        chk(tag, bus_if.dout, exp);
    endtask

    initial begin
        logic [31:0] old;
        logic        en, rn;
        logic [9:0]  aa, ab;

        aresetn     = 1'b0;
        bus_if.enb  = 1'b0;
        bus_if.wea  = 4'h0;
        bus_if.web  = 4'h0;
        bus_if.ada  = '0;
        bus_if.adb  = '0;
        bus_if.dina = '0;
        bus_if.dinb = '0;
        repeat (3) @(posedge aclk);

        // Fill the whole array through port B so every word has a known value.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 4'h0, 4'hF, 10'(i), 10'(i), 32'h0, $urandom, 1'b1, 1'b0, "init");

        // Refill a full line through port B.
        for (int k = 0; k < 16; k++)
            step(1'b1, 4'h0, 4'hF, 10'h000, 10'(10'h040 + k), 32'h0, 32'h1000 + k, 1'b1, 1'b0, "refill");
        peek(1'b1, 10'h000, 10'h040, 32'h1000, "refill_w0");
        peek(1'b1, 10'h000, 10'h047, 32'h1007, "refill_w7");
        peek(1'b1, 10'h000, 10'h04F, 32'h100F, "refill_w15");

        // Partial-word store.
        step(1'b0, 4'hF, 4'h0, 10'h041, 10'h000, 32'h11223344, 32'h0, 1'b1, 1'b1, "sw_full");
        step(1'b0, 4'b0010, 4'h0, 10'h041, 10'h000, 32'hAABBCCDD, 32'h0, 1'b1, 1'b1, "sb_lane1");
        peek(1'b0, 10'h041, 10'h000, 32'h1122CC44, "sb_result");

        // Combinational read: address change with no clock edge in between.
        @(negedge aclk);
        bus_if.enb = 1'b0; bus_if.wea = 4'h0; bus_if.web = 4'h0; bus_if.ada = 10'h040;
        #1 chk("async_a40", bus_if.dout, 32'h1000);
        bus_if.ada = 10'h041;
        #1 chk("async_a41", bus_if.dout, 32'h1122CC44);

        // Collision: port B owns the lanes it writes, port A keeps the rest.
        step(1'b1, 4'hF, 4'b0011, 10'h010, 10'h010, 32'hAAAAAAAA, 32'h5555BBBB, 1'b1, 1'b1, "coll_pre");
        peek(1'b1, 10'h000, 10'h010, 32'hAAAABBBB, "coll_b_sel");
        peek(1'b0, 10'h010, 10'h000, 32'hAAAABBBB, "coll_a_sel");

        // Port-B gating and output steering.
        step(1'b1, 4'h0, 4'hF, 10'h000, 10'h020, 32'h0, 32'h0BADF00D, 1'b1, 1'b1, "gate_pre20");
        step(1'b0, 4'hF, 4'h0, 10'h021, 10'h000, 32'h12345678, 32'h0, 1'b1, 1'b1, "gate_pre21");
        step(1'b0, 4'h0, 4'hF, 10'h021, 10'h020, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1, "gate_try");
        peek(1'b1, 10'h021, 10'h020, 32'h0BADF00D, "gate_enb1");
        peek(1'b0, 10'h021, 10'h020, 32'h12345678, "gate_enb0");

        // Reset suppresses writes; releasing it re-enables them at the next edge.
        old = model[10'h030];
        step(1'b0, 4'hF, 4'h0, 10'h030, 10'h000, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1, "rst_hold");
        step(1'b1, 4'hF, 4'hF, 10'h030, 10'h030, 32'hCAFEF00D, 32'h01234567, 1'b0, 1'b1, "rst_hold_b");
        peek(1'b0, 10'h030, 10'h000, old, "rst_unchanged");
        step(1'b0, 4'hF, 4'h0, 10'h030, 10'h000, 32'hCAFEF00D, 32'h0, 1'b1, 1'b1, "rst_release");
        peek(1'b0, 10'h030, 10'h000, 32'hCAFEF00D, "rst_written");

        // Random traffic with frequent address collisions and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            en = 1'($urandom);
            rn = ($urandom_range(0, 19) != 0);
            aa = 10'($urandom_range(0, 63));
            ab = ($urandom_range(0, 2) == 0) ? aa : 10'($urandom_range(0, 63));
            step(en, 4'($urandom), 4'($urandom), aa, ab, $urandom, $urandom, rn, 1'b1, "rand");
        end
        aresetn = 1'b1;

        // Final sweep of the region touched by random traffic.
        for (int i = 0; i < 64; i++)
            peek(1'b0, 10'(i), 10'h000, model[i], "sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
